// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing a 4-way operand mux among four requesters.
// Drives the mux select and a valid/ready handshake toward the ALU stage,
// and limits each grant to HOLD_MAX beats while others are waiting.
module mux4_rr_arbiter #(
    parameter int unsigned HOLD_MAX = 4,
    parameter int unsigned CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       out_ready,
    output logic [3:0] gnt,
    output logic       sel0,
    output logic       sel1,
    output logic       out_valid,
    output logic [3:0] ack,
    output logic       busy
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(HOLD_MAX - 1);

    state_t           state;
    logic [3:0]       gnt_q;
    logic [1:0]       sel_q;
    logic [1:0]       last_q;
    logic [CNT_W-1:0] beat_cnt;
    logic             busy_q;

    logic       req_g;
    logic       xfer;
    logic [3:0] others;
    logic [2:0] pick_all;
    logic [2:0] pick_oth;

    // Returns {found, index}: first asserted candidate after 'last', wrapping.
    function automatic logic [2:0] rr_pick(input logic [3:0] cand,
                                           input logic [1:0] last);
        logic [2:0] r;
        logic [1:0] idx;
        r = '0;
        for (int unsigned k = 1; k <= 4; k++) begin
            idx = last + k[1:0];
            if (!r[2] && cand[idx]) begin
                r = {1'b1, idx};
            end
        end
        return r;
    endfunction

    // Handshake and arbitration candidates, derived from the current grant.
    always_comb begin
        req_g    = |(gnt_q & req);
        xfer     = req_g & out_ready;
        others   = req & ~gnt_q;
        pick_all = rr_pick(req, last_q);
        pick_oth = rr_pick(others, last_q);
    end

    // Grant FSM: IDLE arbitrates over all requests, GRANT counts beats and
    // hands off on burst limit or when the grantee drops its request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt_q    <= '0;
            sel_q    <= '0;
            last_q   <= 2'd3;
            beat_cnt <= '0;
            busy_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_all[2]) begin
                        state    <= GRANT;
                        gnt_q    <= 4'b0001 << pick_all[1:0];
                        sel_q    <= pick_all[1:0];
                        last_q   <= pick_all[1:0];
                        beat_cnt <= '0;
                        busy_q   <= 1'b1;
                    end
                end
                GRANT: begin
                    if (!req_g) begin
                        beat_cnt <= '0;
                        if (pick_oth[2]) begin
                            gnt_q  <= 4'b0001 << pick_oth[1:0];
                            sel_q  <= pick_oth[1:0];
                            last_q <= pick_oth[1:0];
                        end else begin
                            state  <= IDLE;
                            gnt_q  <= '0;
                            busy_q <= 1'b0;
                        end
                    end else if (xfer) begin
                        if (beat_cnt < LAST_BEAT) begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end else begin
                            beat_cnt <= '0;
                            if (pick_oth[2]) begin
                                gnt_q  <= 4'b0001 << pick_oth[1:0];
                                sel_q  <= pick_oth[1:0];
                                last_q <= pick_oth[1:0];
                            end
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    gnt_q  <= '0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    // Output mapping; valid and ack follow req/out_ready combinationally.
    always_comb begin
        gnt       = gnt_q;
        sel0      = sel_q[0];
        sel1      = sel_q[1];
        busy      = busy_q;
        out_valid = req_g;
        ack       = gnt_q & {4{xfer}};
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: default HOLD_MAX=4 instance plus a
// HOLD_MAX=1 instance sharing the same inputs.
module tb_mux4_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       out_ready;
    logic [3:0] gnt;
    logic       sel0;
    logic       sel1;
    logic       out_valid;
    logic [3:0] ack;
    logic       busy;

    logic [3:0] h1_gnt;
    logic       h1_sel0;
    logic       h1_sel1;
    logic       h1_out_valid;
    logic [3:0] h1_ack;
    logic       h1_busy;

    int n_tests = 0;
    int n_fail  = 0;

    mux4_rr_arbiter #(.HOLD_MAX(4), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .out_ready(out_ready),
        .gnt(gnt), .sel0(sel0), .sel1(sel1), .out_valid(out_valid),
        .ack(ack), .busy(busy)
    );

    mux4_rr_arbiter #(.HOLD_MAX(1), .CNT_W(4)) dut_h1 (
        .clk(clk), .rst_n(rst_n), .req(req), .out_ready(out_ready),
        .gnt(h1_gnt), .sel0(h1_sel0), .sel1(h1_sel1), .out_valid(h1_out_valid),
        .ack(h1_ack), .busy(h1_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [3:0] e;
        logic [3:0] eh;
        int t;

        rst_n     = 1'b0;
        req       = 4'b0000;
        out_ready = 1'b0;
        #2;
        check("rst_gnt",   gnt,         8'h0);
        check("rst_sel",   {sel1,sel0}, 8'h0);
        check("rst_valid", out_valid,   8'h0);
        check("rst_ack",   ack,         8'h0);
        check("rst_busy",  busy,        8'h0);

        // Single requester 0
        #10;
        rst_n     = 1'b1;
        req       = 4'b0001;
        out_ready = 1'b1;
        #1;
        check("idle_valid", out_valid, 8'h0);
        check("idle_ack",   ack,       8'h0);
        tick();
        check("r0_gnt",   gnt,         8'h1);
        check("r0_sel",   {sel1,sel0}, 8'h0);
        check("r0_valid", out_valid,   8'h1);
        check("r0_busy",  busy,        8'h1);
        for (int i = 0; i < 4; i++) begin
            check("r0_ack", ack, 8'h1);
            tick();
        end
        check("r0_hold_gnt", gnt, 8'h1);
        req = 4'b0000;
        #1;
        check("r0_drop_ack", ack, 8'h0);
        tick();
        check("r0_idle_gnt",  gnt,  8'h0);
        check("r0_idle_busy", busy, 8'h0);

        // Requester 1 drops mid-burst with requester 3 pending
        req = 4'b0010;
        tick();
        check("r1_gnt", gnt, 8'h2);
        check("r1_sel", {sel1,sel0}, 8'h1);
        req = 4'b1010;
        #1;
        check("r1_ack", ack, 8'h2);
        tick();
        tick();
        req = 4'b1000;
        #1;
        check("r1_drop_valid", out_valid, 8'h0);
        check("r1_drop_ack",   ack,       8'h0);
        tick();
        check("r3_gnt", gnt, 8'h8);
        check("r3_sel", {sel1,sel0}, 8'h3);
        check("r3_ack", ack, 8'h8);

        // Asynchronous reset mid-burst while requester 1 holds the grant
        req = 4'b0010;
        tick();
        check("r1b_gnt", gnt, 8'h2);
        tick();
        rst_n = 1'b0;
        #1;
        check("arst_gnt",   gnt,         8'h0);
        check("arst_sel",   {sel1,sel0}, 8'h0);
        check("arst_valid", out_valid,   8'h0);
        check("arst_ack",   ack,         8'h0);
        check("arst_busy",  busy,        8'h0);
        @(negedge clk);
        rst_n     = 1'b1;
        req       = 4'b1111;
        out_ready = 1'b1;

        // Full load: 4 beats per grant, order 0,1,2,3,0; HOLD_MAX=1 rotates each beat
        tick();
        for (int g = 0; g < 5; g++) begin
            for (int b = 0; b < 4; b++) begin
                e = 4'b0001 << (g % 4);
                t = g * 4 + b;
                eh = 4'b0001 << (t % 4);
                check("full_gnt", gnt,         8'(e));
                check("full_sel", {sel1,sel0}, 8'(g % 4));
                check("full_ack", ack,         8'(e));
                check("h1_gnt",   h1_gnt,      8'(eh));
                tick();
            end
        end
        check("full_next_gnt", gnt, 8'h2);

        // Stall on requester 2 with requester 0 also pending
        req       = 4'b0101;
        out_ready = 1'b0;
        #1;
        check("pre_stall_ack", ack, 8'h0);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("stall_gnt",   gnt,         8'h4);
            check("stall_sel",   {sel1,sel0}, 8'h2);
            check("stall_valid", out_valid,   8'h1);
            check("stall_ack",   ack,         8'h0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            check("unstall_ack", ack, 8'h4);
            tick();
        end
        check("after_stall_gnt", gnt, 8'h1);
        check("after_stall_sel", {sel1,sel0}, 8'h0);

        // Lone requester 3 keeps its grant across the beat-count wrap
        req = 4'b1000;
        tick();
        for (int i = 0; i < 10; i++) begin
            check("lone_gnt", gnt,         8'h8);
            check("lone_sel", {sel1,sel0}, 8'h3);
            check("lone_ack", ack,         8'h8);
            tick();
        end
        req = 4'b0000;
        tick();
        check("end_gnt",  gnt,         8'h0);
        check("end_busy", busy,        8'h0);
        check("end_sel",  {sel1,sel0}, 8'h3);
        tick();
        check("noreq_ready_ack", ack, 8'h0);
        check("noreq_ready_gnt", gnt, 8'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
